fc_layer_ctrl: RTL and testbench
================================

# fc_layer_ctrl

Control FSM for one fully-connected layer stage of the network pipeline (N-entry input vector, M outputs, P parallel MAC lanes). It accepts an input vector over a valid/ready stream and writes it into the layer's x-memory. It then sequences the x and weight memory reads and the MAC enables for each group of P outputs, and streams the P results per group to the next layer over valid/ready. It drives control only; the 16-bit signed data path (memories, MACs, output register) stays in the layer datapath.

## Interface
- N, 8, input vector length (≥2)
- M, 8, output vector length; M % P == 0
- P, 2, parallel MAC lanes
- MAC_LAT, 1, cycles from last en_acc to accumulator result valid (≥1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- s_valid  in  1  upstream data_in valid
- s_ready  out  1  controller accepts data_in this cycle
- m_valid  out  1  output register entry out_sel valid downstream
- m_ready  in  1  downstream accepts
- wr_en_x  out  1  write data_in to x-memory at addr_x
- addr_x  out  $clog2(N)  x-memory address (write in LOAD, read in COMPUTE)
- addr_w  out  $clog2(N*M/P)  weight address, common to all P banks
- clear_acc  out  1  MAC loads product instead of accumulating
- en_acc  out  1  MAC update enable
- out_load  out  1  latch P accumulator results into output register
- out_sel  out  max(1,$clog2(P))  output register entry driven to data_out

## Operation
- States: LOAD, COMPUTE, WAIT, DRAIN. Counters: k (0..N-1), g (group 0..M/P-1), j (0..P-1), w (0..MAC_LAT).
- LOAD: s_ready=1; wr_en_x = s_valid; addr_x = k; k++ on each accept. On the Nth accept: k←0, g←0, next state COMPUTE.
- COMPUTE: addr_x=k, addr_w=g*N+k, k++ every cycle, no stalls. After k=N-1: next state WAIT, k←0.
- Memories have 1-cycle read latency. The controller delays enables by one cycle: en_acc=1 on the cycle after each COMPUTE cycle; clear_acc=1 only with the first en_acc of a group.
- WAIT: counts MAC_LAT cycles after the last en_acc. out_load=1 on the final WAIT cycle, then next state DRAIN with j←0.
- DRAIN: m_valid=1, out_sel=j. On m_valid&&m_ready: j++. After the P-th handshake:
  - if g==M/P-1: go to LOAD, k←0.
  - else: g++, go to COMPUTE.
- s_valid is ignored outside LOAD (s_ready=0). m_ready is ignored outside DRAIN.
- Outputs are decoded from state/counters. wr_en_x is combinational on s_valid.

## Timing
- While reset=0, and on the first edge after it is sampled low: state LOAD, all counters 0. All outputs are 0, including s_ready, which is gated by reset.
- s_ready=1 from the first cycle with reset=1.
- The last accept of a vector at cycle t puts COMPUTE in t+1; s_ready=0 from t+1.
- Group timeline (COMPUTE cycles c0..cN-1):
  - en_acc in c1..cN
  - clear_acc in c1
  - out_load in cN+MAC_LAT
  - m_valid from cN+MAC_LAT+1
- Per group, with no backpressure: N+MAC_LAT+P+1 cycles. Per vector: N + (M/P)·that.
- A DRAIN stall (m_ready=0) holds out_sel and m_valid indefinitely.
- The last DRAIN handshake of the last group makes s_ready=1 on the next cycle.
- Reset asserted in any state takes effect at the next edge. A partial vector and an in-flight group are discarded, and no further en_acc/out_load is issued.
- Wrap-around: addr_w returns to 0 only via LOAD; g never exceeds M/P-1.

## Structure
- fc_layer_ctrl_pkg: state enum (LOAD, COMPUTE, WAIT, DRAIN) and a width helper for max(1,$clog2(x)).
- One sub-module, mod_counter (parameterized modulus, enable, sync active-low clear, terminal-count output), instanced for k, g, j and w.
- The addr_w computation g*N+k is kept as a registered running base, so no multiplier is needed.

## Test plan
Use N=4, M=4, P=2, MAC_LAT=1.
- Reset 3 cycles with s_valid=1 → s_ready, m_valid, wr_en_x, en_acc all 0; s_ready=1 on the first cycle after release.
- 4 back-to-back s_valid beats → wr_en_x with addr_x 0,1,2,3; s_ready=0 on the following cycle.
- Gapped s_valid pattern 1,0,0,1,1,0,1 → addr_x advances only on accepted beats; COMPUTE entered after the 4th accept.
- Group 0 → addr_w 0..3 with addr_x 0..3; en_acc for 4 cycles from c1; clear_acc only at c1; out_load at c5; m_valid at c6. Group 1 → addr_w 4..7.
- DRAIN with m_ready pattern 1,0,0,1 → out_sel 0 then holds 1 through the stall; group 1 starts the cycle after the 2nd handshake. After group 1 drains, s_ready=1.
- Reset asserted at COMPUTE k=2 → all outputs 0 on the next cycle. A new 4-beat vector then writes from addr_x=0 with a correct full sequence.

Source files
------------

// File: rtl/fc_layer_ctrl_pkg.sv
// Shared types and helpers for the fully-connected layer controller.
// Holds the FSM state encoding and a minimum-1 width function.
package fc_layer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_WAIT,
    S_DRAIN
  } state_e;

  function automatic int unsigned cw(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_mod_counter.sv
// Modulo-MOD up-counter with enable, sync active-low clear and
// terminal-count flag; wraps to zero when enabled at MOD-1.
module mod_counter
  import fc_layer_ctrl_pkg::*;
#(
  parameter int unsigned MOD = 2
) (
  input  logic                 clk,
  input  logic                 clr_ni,
  input  logic                 en_i,
  output logic [cw(MOD)-1:0]   cnt_o,
  output logic                 tc_o
);

  localparam int unsigned W = cw(MOD);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == W'(MOD - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Control FSM for one FC layer stage: loads x, sequences MAC reads
// per group of P outputs, then drains P results downstream.
module fc_layer_ctrl
  import fc_layer_ctrl_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned M       = 8,
  parameter int unsigned P       = 2,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       wr_en_x,
  output logic [$clog2(N)-1:0]       addr_x,
  output logic [$clog2(N*M/P)-1:0]   addr_w,
  output logic                       clear_acc,
  output logic                       en_acc,
  output logic                       out_load,
  output logic [cw(P)-1:0]           out_sel
);

  localparam int unsigned G  = M / P;
  localparam int unsigned XW = $clog2(N);
  localparam int unsigned AW = $clog2(N * M / P);

  state_e state_q, state_d;

  logic [AW-1:0] base_q, base_d;
  logic          en_q, clr_q;

  logic          k_en, g_en, j_en, w_en;
  logic [XW-1:0] k_cnt;
  logic [cw(G)-1:0] g_cnt;
  logic [cw(P)-1:0] j_cnt;
  logic [cw(MAC_LAT+1)-1:0] w_cnt;
  logic          k_tc, g_tc, j_tc, w_tc;
  logic          unused_cnt;

  mod_counter #(.MOD(N)) u_k (
    .clk(clk), .clr_ni(reset), .en_i(k_en),
    .cnt_o(k_cnt), .tc_o(k_tc)
  );

  mod_counter #(.MOD(G)) u_g (
    .clk(clk), .clr_ni(reset), .en_i(g_en),
    .cnt_o(g_cnt), .tc_o(g_tc)
  );

  mod_counter #(.MOD(P)) u_j (
    .clk(clk), .clr_ni(reset), .en_i(j_en),
    .cnt_o(j_cnt), .tc_o(j_tc)
  );

  mod_counter #(.MOD(MAC_LAT + 1)) u_w (
    .clk(clk), .clr_ni(reset), .en_i(w_en),
    .cnt_o(w_cnt), .tc_o(w_tc)
  );

  assign unused_cnt = ^{g_cnt, w_cnt};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_en     = 1'b0;
    g_en     = 1'b0;
    j_en     = 1'b0;
    w_en     = 1'b0;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    out_load = 1'b0;
    addr_x   = '0;
    addr_w   = '0;
    unique case (state_q)
      S_LOAD: begin
        s_ready = reset;
        k_en    = s_valid;
        addr_x  = k_cnt;
        base_d  = '0;
        if (s_valid && k_tc) begin
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        k_en   = 1'b1;
        addr_x = k_cnt;
        addr_w = base_q + AW'(k_cnt);
        if (k_tc) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        w_en = 1'b1;
        if (w_tc) begin
          out_load = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        m_valid = 1'b1;
        j_en    = m_ready;
        if (m_ready && j_tc) begin
          g_en = 1'b1;
          if (g_tc) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_COMPUTE;
            base_d  = base_q + AW'(N);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign wr_en_x   = s_ready & s_valid;
  assign out_sel   = j_cnt;
  assign en_acc    = en_q;
  assign clear_acc = clr_q;

  // MAC enables trail the read addresses by the 1-cycle memory latency
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_LOAD;
      base_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      en_q    <= (state_q == S_COMPUTE);
      clr_q   <= (state_q == S_COMPUTE) && (k_cnt == '0);
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl with a timeline-based model
// checked every cycle plus hand-computed literal expectations.
module tb_fc_layer_ctrl;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int P   = 2;
  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b0;
  logic       s_ready, m_valid, wr_en_x;
  logic       clear_acc, en_acc, out_load;
  logic [1:0] addr_x;
  logic [2:0] addr_w;
  logic [0:0] out_sel;

  int checks = 0;
  int errors = 0;

  // model: phase 0 = loading, 1 = group in flight
  int mph = 0, mk = 0, mg = 0, mt = 0, mj = 0;
  bit mok = 1'b0;

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int acc = 0;

  always #5 clk = ~clk;

  fc_layer_ctrl #(
    .N(N), .M(M), .P(P), .MAC_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .wr_en_x(wr_en_x), .addr_x(addr_x),
    .addr_w(addr_w), .clear_acc(clear_acc),
    .en_acc(en_acc), .out_load(out_load),
    .out_sel(out_sel)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic sv,
                      input logic mr);
    @(posedge clk);
    #1;
    reset   = r;
    s_valid = sv;
    m_ready = mr;
    #2;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      mph <= 0; mk <= 0; mg <= 0; mt <= 0; mj <= 0;
      mok <= 1'b1;
    end else if (mph == 0) begin
      if (s_valid) begin
        if (mk == N - 1) begin
          mph <= 1; mk <= 0; mg <= 0; mt <= 0; mj <= 0;
        end else begin
          mk <= mk + 1;
        end
      end
    end else if (mt < N + LAT + 1) begin
      mt <= mt + 1;
    end else if (m_ready) begin
      if (mj == P - 1) begin
        mj <= 0;
        if (mg == M / P - 1) begin
          mph <= 0;
        end else begin
          mg <= mg + 1;
          mt <= 0;
        end
      end else begin
        mj <= mj + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit grp;
    bit e_mv;
    if (mok) begin
      grp  = (mph == 1);
      e_mv = grp && (mt > N + LAT);
      chk("s_ready", s_ready, reset && !grp);
      chk("wr_en_x", wr_en_x, reset && !grp && s_valid);
      chk("addr_x", addr_x,
          !grp ? mk : ((mt < N) ? mt : 0));
      chk("addr_w", addr_w,
          (grp && mt < N) ? mg * N + mt : 0);
      chk("en_acc", en_acc, grp && mt >= 1 && mt <= N);
      chk("clear_acc", clear_acc, grp && mt == 1);
      chk("out_load", out_load, grp && mt == N + LAT);
      chk("m_valid", m_valid, e_mv);
      chk("out_sel", out_sel, e_mv ? mj : 0);
    end
  end

  initial begin
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_wr_en_x", wr_en_x, 0);
      chk("rst_en_acc", en_acc, 0);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("bb_s_ready", s_ready, 1);
      chk("bb_wr_en_x", wr_en_x, 1);
      chk("bb_addr_x", addr_x, i);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("g0_s_ready", s_ready, 0);
      chk("g0_addr_w", addr_w, i);
      chk("g0_addr_x", addr_x, i);
      chk("g0_en_acc", en_acc, i >= 1);
      chk("g0_clear_acc", clear_acc, i == 1);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("g0_c4_en_acc", en_acc, 1);
    chk("g0_c4_out_load", out_load, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("g0_c5_out_load", out_load, 1);
    chk("g0_c5_en_acc", en_acc, 0);
    chk("g0_c5_m_valid", m_valid, 0);

    step(1'b1, 1'b0, 1'b1);
    chk("dr_c6_m_valid", m_valid, 1);
    chk("dr_c6_out_sel", out_sel, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("dr_c7_out_sel", out_sel, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("dr_c8_m_valid", m_valid, 1);
    chk("dr_c8_out_sel", out_sel, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("dr_c9_out_sel", out_sel, 1);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("g1_addr_w", addr_w, 4 + i);
      chk("g1_en_acc", en_acc, i >= 1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("g1_out_load", out_load, 1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("g1_last_out_sel", out_sel, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("reload_s_ready", s_ready, 1);
    chk("reload_m_valid", m_valid, 0);

    for (int i = 0; i < 7; i++) begin
      step(1'b1, pat[i][0], 1'b0);
      chk("gap_addr_x", addr_x, acc);
      chk("gap_wr_en_x", wr_en_x, pat[i]);
      if (pat[i] != 0) acc++;
    end
    step(1'b1, 1'b0, 1'b0);
    chk("gap_c0_s_ready", s_ready, 0);
    chk("gap_c0_addr_w", addr_w, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_c2_addr_x", addr_x, 2);
    step(1'b0, 1'b0, 1'b0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_en_acc", en_acc, 0);
    chk("mrst_clear_acc", clear_acc, 0);
    chk("mrst_out_load", out_load, 0);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_addr_x", addr_x, 0);
    chk("mrst_addr_w", addr_w, 0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("nv_addr_x", addr_x, i);
      chk("nv_wr_en_x", wr_en_x, 1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("nv_end_s_ready", s_ready, 1);
    step(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
